// File: rtl/lsu_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lsu_align_ctrl
// Handshaked load/store alignment: byte enables, two-beat split, load merge/extend.
// Rev    : 1.0
// ============================================================================
module lsu_align_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mem_r,
    input  logic              req_mem_w,
    input  logic [2:0]        req_funct3,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN/8-1:0] mem_wen_n,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB  = XLEN / 8;
    localparam int OW  = $clog2(NB);
    localparam int SHW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_addr;
    logic [2:0]        r_funct3;
    logic              r_is_load;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata0;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;

    logic              w_legal;
    logic [OW-1:0]     w_off;
    logic [4:0]        w_size;
    logic [4:0]        w_end;
    logic              w_split;
    logic [2*NB-1:0]   w_span;
    logic [2*XLEN-1:0] w_bitmask;
    logic [2*XLEN-1:0] w_wlane;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_hi;
    logic [2*XLEN-1:0] w_rshift;
    logic [XLEN-1:0]   w_asm;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_tmp;
    logic [XLEN-1:0]   w_zext;
    logic signed [XLEN-1:0] w_sext;
    logic [XLEN-1:0]   w_ext;
    logic [AW-1:0]     w_base;

    always_comb begin
        w_legal = 1'b0;
        if (req_mem_r && !req_mem_w) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = (XLEN == 64);
                default:                                w_legal = 1'b0;
            endcase
        end else if (req_mem_w && !req_mem_r) begin
            w_legal = !req_funct3[2] && ((req_funct3[1:0] != 2'b11) || (XLEN == 64));
        end
    end

    assign w_off   = r_addr[OW-1:0];
    assign w_size  = 5'd1 << r_funct3[1:0];
    assign w_end   = 5'(w_off) + w_size;
    assign w_split = (w_end > 5'(NB));

    // Byte lanes touched across a two-word window; upper half belongs to BEAT1.
    always_comb begin
        w_span    = '0;
        w_bitmask = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            w_span[i]             = (i >= int'(w_off)) && (i < int'(w_end));
            w_bitmask[8*i +: 8]   = {8{w_span[i]}};
        end
    end

    assign w_wlane = ({{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000}) & w_bitmask;

    // The final beat's data comes straight off the bus; the first beat of a split is latched.
    assign w_lo     = (r_state == S_BEAT0) ? mem_rdata : r_rdata0;
    assign w_hi     = (r_state == S_BEAT1) ? mem_rdata : '0;
    assign w_rshift = {w_hi, w_lo} >> {w_off, 3'b000};
    assign w_asm    = w_rshift[XLEN-1:0];

    assign w_shamt = SHW'(XLEN) - SHW'({w_size, 3'b000});
    assign w_tmp   = w_asm << w_shamt;
    assign w_zext  = w_tmp >> w_shamt;
    assign w_sext  = $signed(w_tmp) >>> w_shamt;
    assign w_ext   = r_funct3[2] ? w_zext : $unsigned(w_sext);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)  w_next = w_legal ? S_BEAT0 : S_RESP;
            S_BEAT0: if (mem_ack)    w_next = w_split ? S_BEAT1 : S_RESP;
            S_BEAT1: if (mem_ack)    w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_funct3     <= '0;
            r_is_load    <= 1'b0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr       <= req_addr;
                        r_funct3     <= req_funct3;
                        r_is_load    <= req_mem_r;
                        r_wdata      <= req_wdata;
                        r_resp_rdata <= '0;
                        r_resp_err   <= !w_legal;
                    end
                end
                S_BEAT0: begin
                    if (mem_ack && r_is_load) begin
                        if (w_split) r_rdata0     <= mem_rdata;
                        else         r_resp_rdata <= w_ext;
                    end
                end
                S_BEAT1: begin
                    if (mem_ack && r_is_load) r_resp_rdata <= w_ext;
                end
                default: ;
            endcase
        end
    end

    assign w_base = {r_addr[AW-1:OW], {OW{1'b0}}};

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_req    = (r_state == S_BEAT0) || (r_state == S_BEAT1);

    always_comb begin
        mem_addr  = '0;
        mem_wen_n = '1;
        mem_wdata = '0;
        if (r_state == S_BEAT0) begin
            mem_addr = w_base;
            if (!r_is_load) begin
                mem_wen_n = ~w_span[NB-1:0];
                mem_wdata = w_wlane[XLEN-1:0];
            end
        end else if (r_state == S_BEAT1) begin
            mem_addr = w_base + AW'(NB);
            if (!r_is_load) begin
                mem_wen_n = ~w_span[2*NB-1:NB];
                mem_wdata = w_wlane[2*XLEN-1:XLEN];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_align_ctrl
// Scoreboard bench driving a 32-bit and a 64-bit unit through one muxed view.
// Rev    : 1.0
// ============================================================================
module tb_lsu_align_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b0;
    logic        sel64      = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_mem_r  = 1'b0;
    logic        req_mem_w  = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr   = '0;
    logic [63:0] req_wdata  = '0;
    logic        resp_ready = 1'b1;
    logic        mem_ack    = 1'b0;
    logic [63:0] mem_rdata  = '0;

    logic        rr32, rv32, re32, mq32;
    logic [31:0] rd32, ma32, mw32;
    logic [3:0]  wn32;
    logic        rr64, rv64, re64, mq64;
    logic [63:0] rd64, mw64;
    logic [31:0] ma64;
    logic [7:0]  wn64;

    logic        req_ready, resp_valid, resp_err, mem_req;
    logic [63:0] resp_rdata, mem_wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wen_n;

    lsu_align_ctrl #(.XLEN(32), .AW(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel64), .req_ready(rr32),
        .req_mem_r(req_mem_r), .req_mem_w(req_mem_w), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_ready(resp_ready), .resp_rdata(rd32), .resp_err(re32),
        .mem_req(mq32), .mem_ack(mem_ack && !sel64), .mem_addr(ma32),
        .mem_wen_n(wn32), .mem_wdata(mw32), .mem_rdata(mem_rdata[31:0])
    );

    lsu_align_ctrl #(.XLEN(64), .AW(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel64), .req_ready(rr64),
        .req_mem_r(req_mem_r), .req_mem_w(req_mem_w), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_ready(resp_ready), .resp_rdata(rd64), .resp_err(re64),
        .mem_req(mq64), .mem_ack(mem_ack && sel64), .mem_addr(ma64),
        .mem_wen_n(wn64), .mem_wdata(mw64), .mem_rdata(mem_rdata)
    );

    always_comb begin
        req_ready  = sel64 ? rr64 : rr32;
        resp_valid = sel64 ? rv64 : rv32;
        resp_err   = sel64 ? re64 : re32;
        resp_rdata = sel64 ? rd64 : {32'h0, rd32};
        mem_req    = sel64 ? mq64 : mq32;
        mem_addr   = sel64 ? ma64 : ma32;
        mem_wen_n  = sel64 ? wn64 : {4'hF, wn32};
        mem_wdata  = sel64 ? mw64 : {32'h0, mw32};
    end

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  wen_n;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
    } beat_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [7:0] wn, input logic [63:0] wd,
                             input logic [63:0] rd, input int dly);
        beat_t b;
        b.addr = a; b.wen_n = wn; b.wdata = wd; b.rdata = rd; b.delay = dly;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic [63:0] rd, input logic err, input int lat);
        resp_t r;
        r.rdata = rd; r.err = err; r.lat = lat;
        resp_q.push_back(r);
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] wd);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("issue_timeout", n, 0);
        req_valid = 1'b1; req_mem_r = r; req_mem_w = w;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_mem_r = 1'b0; req_mem_w = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (resp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", n, 0);
        check("beats_left", beat_q.size(), 0);
    endtask

    // Monitor and memory responder share one process so ordering within a cycle is fixed.
    logic        prev_wait = 1'b0, prev_rv = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_ma;
    logic [7:0]  prev_wn;
    logic [63:0] prev_mw, prev_rd;
    logic        prev_err;
    int          wcnt = 0, acc_cyc = 0, resp_start = 0;

    initial begin
        beat_t bb;
        resp_t ee;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait = 1'b0; prev_rv = 1'b0; prev_hold = 1'b0;
                wcnt = 0; mem_ack = 1'b0;
            end else begin
                if (prev_wait) begin
                    check("hold_mem_req",   mem_req,   1);
                    check("hold_mem_addr",  mem_addr,  prev_ma);
                    check("hold_mem_wen_n", mem_wen_n, prev_wn);
                    check("hold_mem_wdata", mem_wdata, prev_mw);
                end
                if (prev_hold) begin
                    check("hold_resp_valid", resp_valid, 1);
                    check("hold_resp_rdata", resp_rdata, prev_rd);
                    check("hold_resp_err",   resp_err,   prev_err);
                end
                if (mem_req || resp_valid) check("ready_busy", req_ready, 0);
                if (req_valid && req_ready) acc_cyc = cyc;
                if (resp_valid && !prev_rv) resp_start = cyc;
                if (resp_valid && resp_ready) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", resp_valid, 0);
                    end else begin
                        ee = resp_q.pop_front();
                        check("resp_rdata", resp_rdata, ee.rdata);
                        check("resp_err", resp_err, ee.err);
                        if (ee.lat >= 0) check("resp_latency", resp_start - acc_cyc, ee.lat);
                    end
                end

                mem_ack   = 1'b0;
                mem_rdata = {$urandom, $urandom};
                if (mem_req) begin
                    if (beat_q.size() == 0) begin
                        check("beat_unexpected", mem_req, 0);
                        mem_ack = 1'b1;
                    end else if (wcnt < beat_q[0].delay) begin
                        wcnt++;
                    end else begin
                        bb = beat_q.pop_front();
                        check("mem_addr",  mem_addr,  bb.addr);
                        check("mem_wen_n", mem_wen_n, bb.wen_n);
                        check("mem_wdata", mem_wdata, bb.wdata);
                        mem_ack   = 1'b1;
                        mem_rdata = bb.rdata;
                        wcnt      = 0;
                    end
                end else begin
                    // Stray acks while no beat is pending must be ignored.
                    mem_ack = 1'($urandom_range(0, 1));
                end

                prev_wait = mem_req && !mem_ack;
                prev_ma   = mem_addr;
                prev_wn   = mem_wen_n;
                prev_mw   = mem_wdata;
                prev_rv   = resp_valid;
                prev_hold = resp_valid && !resp_ready;
                prev_rd   = resp_rdata;
                prev_err  = resp_err;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: end of test not reached by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  req_ready,  1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err",   resp_err,   0);
        check("rst_mem_req",    mem_req,    0);
        check("rst_mem_addr",   mem_addr,   0);
        check("rst_mem_wen_n",  mem_wen_n,  8'hFF);
        check("rst_mem_wdata",  mem_wdata,  0);
        check("rst_ready64",    rr64,       1);
        check("rst_wen64",      wn64,       8'hFF);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte and halfword stores, aligned, with garbage above the stored size
        push_beat(32'h100, 8'hF7, 64'hAB000000, 0, 0);  push_resp(0, 0, 2);
        issue(0, 1, 3'b000, 32'h103, 64'h000000AB);  drain();
        push_beat(32'h100, 8'hFD, 64'h0000CD00, 0, 0);  push_resp(0, 0, 2);
        issue(0, 1, 3'b000, 32'h101, 64'h123456CD);  drain();
        push_beat(32'h204, 8'hF3, 64'h12340000, 0, 0);  push_resp(0, 0, 2);
        issue(0, 1, 3'b001, 32'h206, 64'hFFFF1234);  drain();

        // Split word store
        push_beat(32'h100, 8'hF3, 64'hBEEF0000, 0, 0);
        push_beat(32'h104, 8'hFC, 64'h0000DEAD, 0, 0);  push_resp(0, 0, 3);
        issue(0, 1, 3'b010, 32'h102, 64'hDEADBEEF);  drain();

        // Split halfword loads, signed and unsigned
        push_beat(32'h200, 8'hFF, 0, 64'h11223344, 0);
        push_beat(32'h204, 8'hFF, 0, 64'h55667788, 0);  push_resp(64'hFFFF8811, 0, 3);
        issue(1, 0, 3'b001, 32'h203, 0);  drain();
        push_beat(32'h200, 8'hFF, 0, 64'h11223344, 0);
        push_beat(32'h204, 8'hFF, 0, 64'h55667788, 0);  push_resp(64'h00008811, 0, 3);
        issue(1, 0, 3'b101, 32'h203, 0);  drain();

        // Byte loads
        push_beat(32'h200, 8'hFF, 0, 64'h00008000, 0);  push_resp(64'hFFFFFF80, 0, 2);
        issue(1, 0, 3'b000, 32'h201, 0);  drain();
        push_beat(32'h200, 8'hFF, 0, 64'h00008000, 0);  push_resp(64'h00000080, 0, 2);
        issue(1, 0, 3'b100, 32'h201, 0);  drain();

        // Illegal requests never touch memory
        push_resp(0, 1, 1);  issue(1, 0, 3'b011, 32'h10, 0);          drain();
        push_resp(0, 1, 1);  issue(1, 0, 3'b110, 32'h10, 0);          drain();
        push_resp(0, 1, 1);  issue(0, 1, 3'b100, 32'h10, 64'h55);     drain();
        push_resp(0, 1, 1);  issue(1, 1, 3'b010, 32'h10, 0);          drain();
        push_resp(0, 1, 1);  issue(0, 0, 3'b010, 32'h10, 0);          drain();

        // Withheld ack and back-pressured response
        resp_ready = 1'b0;
        push_beat(32'h300, 8'hFF, 0, 64'h80000001, 4);  push_resp(64'h80000001, 0, 6);
        issue(1, 0, 3'b010, 32'h300, 0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("stall_resp_timeout", n, 0);
        repeat (3) @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

        // Reset while the second beat of a split store is pending
        push_beat(32'h100, 8'hF3, 64'hBEEF0000, 0, 0);
        push_beat(32'h104, 8'hFC, 64'h0000DEAD, 0, 1000);  push_resp(0, 0, 3);
        issue(0, 1, 3'b010, 32'h102, 64'hDEADBEEF);
        n = 0;
        @(negedge clk);
        while (!(mem_req && mem_wen_n == 8'hFC) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat1_timeout", n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_req",   mem_req,    0);
        check("arst_mem_wen_n", mem_wen_n,  8'hFF);
        check("arst_mem_addr",  mem_addr,   0);
        check("arst_req_ready", req_ready,  1);
        check("arst_resp_valid", resp_valid, 0);
        beat_q.delete();
        resp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", req_ready, 1);
        push_beat(32'h000, 8'hFF, 0, 64'h7F000000, 0);  push_resp(64'h7F, 0, 2);
        issue(1, 0, 3'b000, 32'h003, 0);  drain();

        // 64-bit unit
        sel64 = 1'b1;
        @(posedge clk); #1;
        push_beat(32'h08, 8'hFF, 0, 64'h8877665544332211, 0);
        push_beat(32'h10, 8'hFF, 0, 64'h00000000CCBBAA99, 0);  push_resp(64'hCCBBAA9988776655, 0, 3);
        issue(1, 0, 3'b011, 32'h0C, 0);  drain();
        push_beat(32'h00, 8'hFF, 0, 64'h89ABCDEF00000000, 0);  push_resp(64'h0000000089ABCDEF, 0, 2);
        issue(1, 0, 3'b110, 32'h04, 0);  drain();
        push_beat(32'h00, 8'hFF, 0, 64'h89ABCDEF00000000, 0);  push_resp(64'hFFFFFFFF89ABCDEF, 0, 2);
        issue(1, 0, 3'b010, 32'h04, 0);  drain();
        push_beat(32'h00, 8'h07, 64'h4455667788000000, 0, 0);
        push_beat(32'h08, 8'hF8, 64'h0000000000112233, 0, 0);  push_resp(0, 0, 3);
        issue(0, 1, 3'b011, 32'h03, 64'h1122334455667788);  drain();
        push_resp(0, 1, 1);  issue(0, 1, 3'b100, 32'h10, 0);  drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
